accum_bank_seq: RTL and testbench
=================================

// Module: accum_bank_seq
// PURPOSE
//  Sequencer for a bank of NUM_ACC accum instances. Accepts one job (window length),
//  clears the bank, streams WINDOW beats of inc vectors into it under valid/ready and
//  collects trigger pulses. Returns a sticky per-accumulator spike vector plus a total
//  fire count to the downstream layer stage.
// PARAMETERS
//  NUM_ACC   8   number of accum instances driven (width of inc/trigger vectors)
//  WIN_W     10  width of window_len_in; max window 2**WIN_W-1 beats
//  CNT_W     16  width of out_count; saturates at all-ones
//  TRIG_LAT  1   cycles from an accepted beat to its trigger response; drain length
// PORTS
//  clk_in          in   1          system clock
//  rst_in          in   1          synchronous reset, active-high
//  start_in        in   1          job request; sampled only in IDLE
//  window_len_in   in   WIN_W      beats in the job; latched on start
//  busy_out        out  1          high from start accept until out handshake
//  in_valid        in   1          inc vector valid
//  in_ready        out  1          high only in RUN
//  in_data         in   NUM_ACC    one inc bit per accumulator
//  acc_rst_out     out  1          bank clear, drives every accum rst_in
//  acc_prop_out    out  1          bank enable, high exactly on accepted beats
//  acc_inc_out     out  NUM_ACC    in_data on accepted beats, else 0
//  acc_trigger_in  in   NUM_ACC    trigger outputs of the bank
//  out_valid       out  1          result valid; held until out_ready
//  out_ready       in   1          downstream accept
//  out_spikes      out  NUM_ACC    OR of triggers per accumulator over the job
//  out_count       out  CNT_W      total trigger pulses over the job (saturating)
//  abort_in        in   1          present only with ACCUM_BANK_SEQ_ABORT_EN
// BEHAVIOUR
//  Reset: state IDLE; busy_out, in_ready, acc_prop_out, out_valid = 0; acc_inc_out,
//   out_spikes, out_count = 0; acc_rst_out = 1 during reset and in CLEAR.
//  FSM IDLE -> CLEAR -> RUN -> DRAIN -> DONE -> IDLE.
//  IDLE: start_in=1 latches window_len_in, busy_out=1 next cycle, go CLEAR.
//   window_len_in=0: go straight to DONE with spikes=0, count=0 (no CLEAR).
//  CLEAR: exactly 1 cycle, acc_rst_out=1, spikes/count zeroed; go RUN.
//  RUN: in_ready=1; beat accepted when in_valid&&in_ready; acc_prop_out and
//   acc_inc_out combinational from accept; beat counter increments per accept;
//   on last accept go DRAIN. Stalls (in_valid=0) hold state, prop low.
//  DRAIN: TRIG_LAT cycles, in_ready=0; then DONE.
//  Collection: in RUN and DRAIN each cycle, spikes |= acc_trigger_in,
//   count += popcount(acc_trigger_in), clamped at 2**CNT_W-1.
//   Triggers outside RUN/DRAIN are ignored.
//  DONE: out_valid=1, outputs stable; on out_valid&&out_ready go IDLE, busy_out=0
//   the next cycle. start_in while busy is ignored (not queued).
//  rst_in mid-job: immediate return to reset state; partial results discarded.
// CONFIGURATION
//  ACCUM_BANK_SEQ_ABORT_EN defined: abort_in port exists; abort_in=1 in any non-IDLE
//   state -> one CLEAR cycle (acc_rst_out=1) then IDLE, no out_valid; abort wins over
//   a same-cycle accept or out handshake. Undefined: port absent, jobs always complete.
// STRUCTURE
//  accum_pkg: state enum typedef (IDLE, CLEAR, RUN, DRAIN, DONE), saturating-add
//   function, default width localparams.
//  Sub-module accum_popcount (NUM_ACC-bit vector -> $clog2(NUM_ACC+1)-bit count).
// TESTING
//  window=5, in_valid=1 always, in_data=8'hFF, triggers tied to acc_inc_out delayed
//   1 cycle -> exactly 5 prop pulses, out_spikes=8'hFF, out_count=40.
//  window=4, in_valid toggled 1,0,1,0.. -> prop only on accepts, job ends after 4th
//   accept, in_ready low from DRAIN on.
//  window=0 -> out_valid one cycle after start, spikes=0, count=0, acc_rst_out never
//   pulsed.
//  CNT_W=4, window=3, all 8 triggers each beat -> out_count=15 (saturated).
//  out_ready held 0 for 10 cycles in DONE -> outputs stable, second start ignored;
//   rst_in pulsed mid-RUN -> all outputs at reset values next cycle.
//  ABORT_EN: abort_in at beat 2 of 6 -> one acc_rst_out cycle, IDLE, no out_valid.

Source files
------------

// File: rtl/accum_bank_seq_pkg.sv
// accum_bank_seq_pkg: shared types, default widths and saturating add for the accum bank sequencer
// Contents: state_t (IDLE, CLEAR, RUN, DRAIN, DONE), DEF_* width defaults, sat_add().
package accum_bank_seq_pkg;

    localparam int DEF_NUM_ACC  = 8;
    localparam int DEF_WIN_W    = 10;
    localparam int DEF_CNT_W    = 16;
    localparam int DEF_TRIG_LAT = 1;

    typedef enum logic [2:0] {IDLE, CLEAR, RUN, DRAIN, DONE} state_t;

    // a + b clamped at max; the 33-bit sum catches wrap for full 32-bit operands
    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b,
                                            input logic [31:0] max);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        return (s > {1'b0, max}) ? max : s[31:0];
    endfunction

endpackage

// File: rtl/accum_bank_seq_if.sv
// accum_bank_seq_if: job, beat stream, bank and result signals of the accum bank sequencer
// Modports: slave = sequencer side, master = upstream/bank/downstream side.
// abort_in exists only when ACCUM_BANK_SEQ_ABORT_EN is defined.
interface accum_bank_seq_if
    import accum_bank_seq_pkg::*;
#(
    parameter int NUM_ACC = DEF_NUM_ACC,
    parameter int WIN_W   = DEF_WIN_W,
    parameter int CNT_W   = DEF_CNT_W
) ();
    logic               start_in;
    logic [WIN_W-1:0]   window_len_in;
    logic               busy_out;
    logic               in_valid;
    logic               in_ready;
    logic [NUM_ACC-1:0] in_data;
    logic               acc_rst_out;
    logic               acc_prop_out;
    logic [NUM_ACC-1:0] acc_inc_out;
    logic [NUM_ACC-1:0] acc_trigger_in;
    logic               out_valid;
    logic               out_ready;
    logic [NUM_ACC-1:0] out_spikes;
    logic [CNT_W-1:0]   out_count;
`ifdef ACCUM_BANK_SEQ_ABORT_EN
    logic               abort_in;
    modport slave (
        input  start_in, window_len_in, in_valid, in_data, acc_trigger_in, out_ready, abort_in,
        output busy_out, in_ready, acc_rst_out, acc_prop_out, acc_inc_out, out_valid,
               out_spikes, out_count
    );
    modport master (
        output start_in, window_len_in, in_valid, in_data, acc_trigger_in, out_ready, abort_in,
        input  busy_out, in_ready, acc_rst_out, acc_prop_out, acc_inc_out, out_valid,
               out_spikes, out_count
    );
`else
    modport slave (
        input  start_in, window_len_in, in_valid, in_data, acc_trigger_in, out_ready,
        output busy_out, in_ready, acc_rst_out, acc_prop_out, acc_inc_out, out_valid,
               out_spikes, out_count
    );
    modport master (
        output start_in, window_len_in, in_valid, in_data, acc_trigger_in, out_ready,
        input  busy_out, in_ready, acc_rst_out, acc_prop_out, acc_inc_out, out_valid,
               out_spikes, out_count
    );
`endif
endinterface

// File: rtl/accum_bank_seq_popcount.sv
// accum_bank_seq_popcount: number of set bits in an N-bit vector
// Ports: v (N) in, cnt ($clog2(N+1)) out.
module accum_bank_seq_popcount #(
    parameter int N = 8,
    parameter int W = $clog2(N + 1)
) (
    input  logic [N-1:0] v,
    output logic [W-1:0] cnt
);
    always_comb begin
        cnt = '0;
        for (int i = 0; i < N; i++) cnt = cnt + W'(v[i]);
    end
endmodule

// File: rtl/accum_bank_seq.sv
// accum_bank_seq: runs one windowed job over a bank of accum instances and reports spikes/fire count
// Ports: clk_in, rst_in (sync, active-high); b = accum_bank_seq_if.slave carrying the job
// request (start_in, window_len_in, busy_out), beat stream (in_valid/in_ready/in_data), bank
// control (acc_rst_out, acc_prop_out, acc_inc_out, acc_trigger_in) and result
// (out_valid/out_ready/out_spikes/out_count).
// Option: ACCUM_BANK_SEQ_ABORT_EN adds abort_in (clear bank, back to IDLE, no result).
module accum_bank_seq
    import accum_bank_seq_pkg::*;
#(
    parameter int NUM_ACC  = DEF_NUM_ACC,
    parameter int WIN_W    = DEF_WIN_W,
    parameter int CNT_W    = DEF_CNT_W,
    parameter int TRIG_LAT = DEF_TRIG_LAT
) (
    input logic               clk_in,
    input logic               rst_in,
    accum_bank_seq_if.slave   b
);
    localparam int PW = $clog2(NUM_ACC + 1);
    localparam int DW = TRIG_LAT > 1 ? $clog2(TRIG_LAT) : 1;
    localparam logic [CNT_W-1:0] CMAX = '1;

    state_t             state;
    logic [WIN_W-1:0]   win;
    logic [WIN_W-1:0]   beats;
    logic [DW-1:0]      dcnt;
    logic               aborting;
    logic [NUM_ACC-1:0] spikes;
    logic [CNT_W-1:0]   count;
    logic [PW-1:0]      pop;
    logic               abort;
    logic               accept;
    logic               collect;

`ifdef ACCUM_BANK_SEQ_ABORT_EN
    assign abort = b.abort_in && state != IDLE;
`else
    assign abort = 1'b0;
`endif

    // abort suppresses a same-cycle beat so the bank never sees a half-cancelled job
    assign accept  = state == RUN && b.in_valid && !abort;
    assign collect = state == RUN || state == DRAIN;

    assign b.busy_out     = state != IDLE;
    assign b.in_ready     = state == RUN;
    assign b.acc_rst_out  = rst_in || state == CLEAR;
    assign b.acc_prop_out = accept;
    assign b.acc_inc_out  = accept ? b.in_data : '0;
    assign b.out_valid    = state == DONE;
    assign b.out_spikes   = spikes;
    assign b.out_count    = count;

    accum_bank_seq_popcount #(.N(NUM_ACC)) u_pop (.v(b.acc_trigger_in), .cnt(pop));

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state    <= IDLE;
            win      <= '0;
            beats    <= '0;
            dcnt     <= '0;
            aborting <= 1'b0;
            spikes   <= '0;
            count    <= '0;
        end else if (abort) begin
            state    <= CLEAR;
            aborting <= 1'b1;
        end else begin
            if (collect) begin
                spikes <= spikes | b.acc_trigger_in;
                count  <= CNT_W'(sat_add(32'(count), 32'(pop), 32'(CMAX)));
            end
            case (state)
                IDLE: if (b.start_in) begin
                    win    <= b.window_len_in;
                    beats  <= '0;
                    spikes <= '0;
                    count  <= '0;
                    state  <= b.window_len_in == '0 ? DONE : CLEAR;
                end
                CLEAR: begin
                    spikes   <= '0;
                    count    <= '0;
                    beats    <= '0;
                    dcnt     <= '0;
                    aborting <= 1'b0;
                    state    <= aborting ? IDLE : RUN;
                end
                RUN: if (accept) begin
                    beats <= beats + 1'b1;
                    if (beats == win - 1'b1) state <= DRAIN;
                end
                DRAIN: begin
                    dcnt <= dcnt + 1'b1;
                    if (dcnt == DW'(TRIG_LAT - 1)) state <= DONE;
                end
                DONE: if (b.out_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_accum_bank_seq.sv
// tb_accum_bank_seq: directed self-checking bench for accum_bank_seq (default and CNT_W=4 instances)
module tb_accum_bank_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    accum_bank_seq_if #(.NUM_ACC(8), .WIN_W(10), .CNT_W(16)) i0 ();
    accum_bank_seq_if #(.NUM_ACC(8), .WIN_W(10), .CNT_W(4))  i1 ();

    accum_bank_seq #(.NUM_ACC(8), .WIN_W(10), .CNT_W(16), .TRIG_LAT(1)) u0 (
        .clk_in(clk), .rst_in(rst), .b(i0));
    accum_bank_seq #(.NUM_ACC(8), .WIN_W(10), .CNT_W(4), .TRIG_LAT(1)) u1 (
        .clk_in(clk), .rst_in(rst), .b(i1));

    // bank model: each accumulator fires one cycle after an increment
    logic [7:0] trig0, trig1, extra0;
    always_ff @(posedge clk) begin
        trig0 <= rst ? 8'h00 : i0.acc_inc_out;
        trig1 <= rst ? 8'h00 : i1.acc_inc_out;
    end
    assign i0.acc_trigger_in = trig0 | extra0;
    assign i1.acc_trigger_in = trig1;

    task automatic test_reset();
        repeat (2) @(negedge clk);
        tests++;
        if (i0.acc_rst_out !== 1'b1 || i0.busy_out !== 1'b0 || i0.in_ready !== 1'b0 ||
            i0.acc_prop_out !== 1'b0 || i0.out_valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_ctrl acc_rst=%b busy=%b rdy=%b prop=%b ov=%b expected 1 0 0 0 0",
                     i0.acc_rst_out, i0.busy_out, i0.in_ready, i0.acc_prop_out, i0.out_valid);
        end
        tests++;
        if (i0.acc_inc_out !== 8'h00 || i0.out_spikes !== 8'h00 || i0.out_count !== 16'd0) begin
            fails++;
            $display("FAIL reset_data inc=%h spikes=%h count=%0d expected 00 00 0",
                     i0.acc_inc_out, i0.out_spikes, i0.out_count);
        end
        rst = 1'b0;
        @(negedge clk);
        tests++;
        if (i0.acc_rst_out !== 1'b0) begin
            fails++;
            $display("FAIL reset_release acc_rst=%b expected 0", i0.acc_rst_out);
        end
    endtask

    task automatic test_window5();
        int pulses = 0;
        bit done = 0;
        i0.start_in = 1'b1; i0.window_len_in = 10'd5; i0.in_valid = 1'b1; i0.in_data = 8'hFF;
        @(negedge clk);
        i0.start_in = 1'b0;
        tests++;
        if (i0.busy_out !== 1'b1 || i0.acc_rst_out !== 1'b1 || i0.in_ready !== 1'b0) begin
            fails++;
            $display("FAIL w5_clear busy=%b acc_rst=%b rdy=%b expected 1 1 0",
                     i0.busy_out, i0.acc_rst_out, i0.in_ready);
        end
        for (int c = 0; c < 50 && !done; c++) begin
            @(negedge clk);
            if (i0.out_valid) done = 1;
            else if (i0.acc_prop_out) pulses++;
        end
        tests++;
        if (!done) begin fails++; $display("FAIL w5_timeout out_valid=0 expected 1"); end
        tests++;
        if (pulses !== 5) begin fails++; $display("FAIL w5_pulses got %0d expected 5", pulses); end
        tests++;
        if (i0.out_spikes !== 8'hFF || i0.out_count !== 16'd40) begin
            fails++;
            $display("FAIL w5_result spikes=%h count=%0d expected ff 40", i0.out_spikes, i0.out_count);
        end
        i0.in_valid = 1'b0; i0.out_ready = 1'b1;
        @(negedge clk);
        i0.out_ready = 1'b0;
        tests++;
        if (i0.out_valid !== 1'b0 || i0.busy_out !== 1'b0) begin
            fails++;
            $display("FAIL w5_handshake ov=%b busy=%b expected 0 0", i0.out_valid, i0.busy_out);
        end
    endtask

    task automatic test_stall();
        int bad = 0;
        i0.start_in = 1'b1; i0.window_len_in = 10'd4; i0.in_data = 8'hA5; i0.in_valid = 1'b0;
        @(negedge clk);
        i0.start_in = 1'b0;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            i0.in_valid = (i % 2) == 0;
            #1;
            if (i0.acc_prop_out !== (i <= 6 && (i % 2) == 0)) begin
                bad++;
                $display("FAIL stall_prop cycle %0d got %b", i, i0.acc_prop_out);
            end
            if (i0.acc_inc_out !== ((i <= 6 && (i % 2) == 0) ? 8'hA5 : 8'h00)) begin
                bad++;
                $display("FAIL stall_inc cycle %0d got %h", i, i0.acc_inc_out);
            end
            if (i0.in_ready !== (i <= 6)) begin
                bad++;
                $display("FAIL stall_ready cycle %0d got %b expected %b", i, i0.in_ready, i <= 6);
            end
            if (i0.out_valid !== (i == 8)) begin
                bad++;
                $display("FAIL stall_ov cycle %0d got %b expected %b", i, i0.out_valid, i == 8);
            end
        end
        tests++;
        if (bad != 0) fails++;
        tests++;
        if (i0.out_spikes !== 8'hA5 || i0.out_count !== 16'd16) begin
            fails++;
            $display("FAIL stall_result spikes=%h count=%0d expected a5 16", i0.out_spikes, i0.out_count);
        end
        i0.in_valid = 1'b0; i0.out_ready = 1'b1;
        @(negedge clk);
        i0.out_ready = 1'b0;
    endtask

    task automatic test_zero_window();
        i0.start_in = 1'b1; i0.window_len_in = 10'd0;
        #1;
        tests++;
        if (i0.acc_rst_out !== 1'b0) begin
            fails++;
            $display("FAIL zero_start acc_rst=%b expected 0", i0.acc_rst_out);
        end
        @(negedge clk);
        i0.start_in = 1'b0;
        tests++;
        if (i0.out_valid !== 1'b1 || i0.acc_rst_out !== 1'b0 || i0.busy_out !== 1'b1) begin
            fails++;
            $display("FAIL zero_done ov=%b acc_rst=%b busy=%b expected 1 0 1",
                     i0.out_valid, i0.acc_rst_out, i0.busy_out);
        end
        tests++;
        if (i0.out_spikes !== 8'h00 || i0.out_count !== 16'd0) begin
            fails++;
            $display("FAIL zero_result spikes=%h count=%0d expected 00 0", i0.out_spikes, i0.out_count);
        end
        i0.out_ready = 1'b1;
        @(negedge clk);
        i0.out_ready = 1'b0;
    endtask

    task automatic test_saturate();
        bit done = 0;
        i1.start_in = 1'b1; i1.window_len_in = 10'd3; i1.in_valid = 1'b1; i1.in_data = 8'hFF;
        @(negedge clk);
        i1.start_in = 1'b0;
        for (int c = 0; c < 50 && !done; c++) begin
            @(negedge clk);
            if (i1.out_valid) done = 1;
        end
        tests++;
        if (!done) begin fails++; $display("FAIL sat_timeout out_valid=0 expected 1"); end
        tests++;
        if (i1.out_count !== 4'hF || i1.out_spikes !== 8'hFF) begin
            fails++;
            $display("FAIL sat_result count=%0d spikes=%h expected 15 ff", i1.out_count, i1.out_spikes);
        end
        i1.in_valid = 1'b0; i1.out_ready = 1'b1;
        @(negedge clk);
        i1.out_ready = 1'b0;
    endtask

    task automatic test_hold();
        bit done = 0;
        int bad = 0;
        i0.start_in = 1'b1; i0.window_len_in = 10'd2; i0.in_valid = 1'b1; i0.in_data = 8'h0F;
        @(negedge clk);
        i0.start_in = 1'b0;
        for (int c = 0; c < 50 && !done; c++) begin
            @(negedge clk);
            if (i0.out_valid) done = 1;
        end
        tests++;
        if (!done) begin fails++; $display("FAIL hold_timeout out_valid=0 expected 1"); end
        i0.in_valid = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (i0.out_valid !== 1'b1 || i0.busy_out !== 1'b1 || i0.out_spikes !== 8'h0F ||
                i0.out_count !== 16'd8) begin
                bad++;
                $display("FAIL hold_stable cycle %0d ov=%b busy=%b spikes=%h count=%0d expected 1 1 0f 8",
                         k, i0.out_valid, i0.busy_out, i0.out_spikes, i0.out_count);
            end
            i0.start_in = k == 3;
            i0.window_len_in = 10'd5;
            extra0 = (k == 5) ? 8'hFF : 8'h00;
            @(negedge clk);
        end
        tests++;
        if (bad != 0) fails++;
        i0.start_in = 1'b0; extra0 = 8'h00; i0.out_ready = 1'b1;
        @(negedge clk);
        i0.out_ready = 1'b0;
        tests++;
        if (i0.busy_out !== 1'b0 || i0.out_valid !== 1'b0) begin
            fails++;
            $display("FAIL hold_release busy=%b ov=%b expected 0 0", i0.busy_out, i0.out_valid);
        end
        @(negedge clk);
        tests++;
        if (i0.busy_out !== 1'b0 || i0.acc_rst_out !== 1'b0) begin
            fails++;
            $display("FAIL hold_no_queue busy=%b acc_rst=%b expected 0 0", i0.busy_out, i0.acc_rst_out);
        end
    endtask

    task automatic test_rst_mid_run();
        i0.start_in = 1'b1; i0.window_len_in = 10'd10; i0.in_valid = 1'b1; i0.in_data = 8'h33;
        @(negedge clk);
        i0.start_in = 1'b0;
        repeat (4) @(negedge clk);
        tests++;
        if (i0.out_spikes !== 8'h33 || i0.in_ready !== 1'b1) begin
            fails++;
            $display("FAIL rstmid_pre spikes=%h rdy=%b expected 33 1", i0.out_spikes, i0.in_ready);
        end
        rst = 1'b1;
        @(negedge clk);
        tests++;
        if (i0.busy_out !== 1'b0 || i0.in_ready !== 1'b0 || i0.acc_prop_out !== 1'b0 ||
            i0.out_valid !== 1'b0 || i0.acc_rst_out !== 1'b1) begin
            fails++;
            $display("FAIL rstmid_ctrl busy=%b rdy=%b prop=%b ov=%b acc_rst=%b expected 0 0 0 0 1",
                     i0.busy_out, i0.in_ready, i0.acc_prop_out, i0.out_valid, i0.acc_rst_out);
        end
        tests++;
        if (i0.out_spikes !== 8'h00 || i0.out_count !== 16'd0 || i0.acc_inc_out !== 8'h00) begin
            fails++;
            $display("FAIL rstmid_data spikes=%h count=%0d inc=%h expected 00 0 00",
                     i0.out_spikes, i0.out_count, i0.acc_inc_out);
        end
        rst = 1'b0;
        @(negedge clk);
        tests++;
        if (i0.busy_out !== 1'b0 || i0.acc_prop_out !== 1'b0 || i0.acc_rst_out !== 1'b0) begin
            fails++;
            $display("FAIL rstmid_idle busy=%b prop=%b acc_rst=%b expected 0 0 0",
                     i0.busy_out, i0.acc_prop_out, i0.acc_rst_out);
        end
        i0.in_valid = 1'b0;
    endtask

`ifdef ACCUM_BANK_SEQ_ABORT_EN
    task automatic test_abort();
        int bad = 0;
        i0.start_in = 1'b1; i0.window_len_in = 10'd6; i0.in_valid = 1'b1; i0.in_data = 8'hFF;
        @(negedge clk);
        i0.start_in = 1'b0;
        @(negedge clk);
        @(negedge clk);
        i0.abort_in = 1'b1;
        #1;
        tests++;
        if (i0.acc_prop_out !== 1'b0 || i0.acc_inc_out !== 8'h00) begin
            fails++;
            $display("FAIL abort_beat prop=%b inc=%h expected 0 00", i0.acc_prop_out, i0.acc_inc_out);
        end
        @(negedge clk);
        i0.abort_in = 1'b0;
        tests++;
        if (i0.acc_rst_out !== 1'b1 || i0.out_valid !== 1'b0) begin
            fails++;
            $display("FAIL abort_clear acc_rst=%b ov=%b expected 1 0", i0.acc_rst_out, i0.out_valid);
        end
        @(negedge clk);
        tests++;
        if (i0.busy_out !== 1'b0 || i0.acc_rst_out !== 1'b0) begin
            fails++;
            $display("FAIL abort_idle busy=%b acc_rst=%b expected 0 0", i0.busy_out, i0.acc_rst_out);
        end
        i0.in_valid = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (i0.out_valid !== 1'b0 || i0.busy_out !== 1'b0) bad++;
        end
        tests++;
        if (bad != 0) begin fails++; $display("FAIL abort_no_result %0d bad cycles expected 0", bad); end
    endtask
`endif

    initial begin
        i0.start_in = 1'b0; i0.window_len_in = '0; i0.in_valid = 1'b0; i0.in_data = '0; i0.out_ready = 1'b0;
        i1.start_in = 1'b0; i1.window_len_in = '0; i1.in_valid = 1'b0; i1.in_data = '0; i1.out_ready = 1'b0;
        extra0 = 8'h00;
`ifdef ACCUM_BANK_SEQ_ABORT_EN
        i0.abort_in = 1'b0;
        i1.abort_in = 1'b0;
`endif
        test_reset();
        test_window5();
        test_stall();
        test_zero_window();
        test_saturate();
        test_hold();
        test_rst_mid_run();
`ifdef ACCUM_BANK_SEQ_ABORT_EN
        test_abort();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
